dcache_ctrl: RTL and testbench

Sequencing controller for the memory stage's data cache and backing data memory. It detects load misses and store write-throughs, runs the multi-cycle backing-memory handshake, drives the cache refill, and raises a stall to the hazard unit until the access completes. It sits between the M-stage pipeline register, the cache, and the data memory port. It replaces the current single-cycle hit/mem mux assumption.

---
 rtl/dcache_ctrl_pkg.sv | 19 +
 rtl/dcache_ctrl_if.sv | 49 ++++
 rtl/dcache_timeout_cnt.sv | 37 +++
 rtl/dcache_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dcache_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared types and constants for the data-cache sequencing controller.
// The optional statistics counters in dcache_ctrl are enabled by DCACHE_CTRL_STATS_EN.
package dcache_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_WAIT = 3'd1,
      FILL    = 3'd2,
      WR_WAIT = 3'd3,
      DONE    = 3'd4,
      ERR     = 3'd5
   } dcache_state_t;

   // Clears the byte offset so backing memory only ever sees word addresses.
   localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

   localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/dcache_ctrl_if.sv
// Bundle of M-stage inputs, backing-memory handshake, refill/bypass outputs and status.
// The controller uses the master modport; the pipeline/memory environment uses slave.
interface dcache_ctrl_if #(
   parameter int DATA_WIDTH        = 32,
   parameter int MEM_ADDRESS_WIDTH = 17
);
   import dcache_ctrl_pkg::*;

   logic                         MemReadM;
   logic                         MemWriteM;
   logic                         HitM;
   logic [MEM_ADDRESS_WIDTH-1:0] AddrM;
   logic [DATA_WIDTH-1:0]        WriteDataM;

   // MemReq is a level request: once raised, MemReq/MemWe/MemAddr/MemWD hold
   // steady until the memory returns a single-cycle MemAck, which completes it.
   logic                         MemReq;
   logic                         MemWe;
   logic [MEM_ADDRESS_WIDTH-1:0] MemAddr;
   logic [DATA_WIDTH-1:0]        MemWD;
   logic                         MemAck;
   logic [DATA_WIDTH-1:0]        MemRD;

   logic                         FillEn;
   logic [MEM_ADDRESS_WIDTH-1:0] FillAddr;
   logic [DATA_WIDTH-1:0]        FillData;
   logic                         BypassValid;
   logic [DATA_WIDTH-1:0]        BypassData;
   logic                         StallMem;
   logic                         ErrTimeout;
   logic [31:0]                  MissCount;
   logic [31:0]                  WriteCount;
   dcache_state_t                dbg_state;

   modport master (
      input  MemReadM, MemWriteM, HitM, AddrM, WriteDataM, MemAck, MemRD,
      output MemReq, MemWe, MemAddr, MemWD, FillEn, FillAddr, FillData,
             BypassValid, BypassData, StallMem, ErrTimeout, MissCount,
             WriteCount, dbg_state
   );

   modport slave (
      output MemReadM, MemWriteM, HitM, AddrM, WriteDataM, MemAck, MemRD,
      input  MemReq, MemWe, MemAddr, MemWD, FillEn, FillAddr, FillData,
             BypassValid, BypassData, StallMem, ErrTimeout, MissCount,
             WriteCount, dbg_state
   );

endinterface

// File: rtl/dcache_timeout_cnt.sv
// Wait-cycle counter for a backing-memory request; tc flags the last allowed cycle.
// Holds at terminal count until cleared.
module dcache_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !tc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/dcache_ctrl.sv
// Memory-stage data-cache controller: load-miss refill, store write-through, pipeline stall.
// Define DCACHE_CTRL_STATS_EN to build the saturating MissCount/WriteCount counters.
module dcache_ctrl import dcache_ctrl_pkg::*; #(
   parameter int DATA_WIDTH        = 32,
   parameter int MEM_ADDRESS_WIDTH = 17,
   parameter int TIMEOUT_CYCLES    = DEFAULT_TIMEOUT_CYCLES
) (
   input logic           CLK,
   input logic           RST,
   dcache_ctrl_if.master bus
);
   localparam logic [MEM_ADDRESS_WIDTH-1:0] ADDR_MASK = WORD_ALIGN_MASK[MEM_ADDRESS_WIDTH-1:0];

   dcache_state_t                state_q, state_d;
   logic [MEM_ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]        rdata_q, rdata_d;
   logic                         mem_req_q, mem_req_d;
   logic                         mem_we_q, mem_we_d;
   logic                         fill_en_q, fill_en_d;
   logic                         bypass_valid_q, bypass_valid_d;
   logic                         stall_q, stall_d;
   logic                         err_q, err_d;
   logic                         start_rd;
   logic                         start_wr;
   logic                         cnt_en;
   logic                         timeout_tc;

   dcache_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk   (CLK),
      .rst_n (RST),
      .clr   (start_rd | start_wr),
      .en    (cnt_en),
      .tc    (timeout_tc)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      start_rd = 1'b0;
      start_wr = 1'b0;
      cnt_en   = 1'b0;

      case (state_q)
         IDLE: begin
            // A load takes priority; a load hit needs nothing from this block.
            if (bus.MemReadM) begin
               if (!bus.HitM) begin
                  start_rd = 1'b1;
                  addr_d   = bus.AddrM & ADDR_MASK;
                  state_d  = RD_WAIT;
               end
            end else if (bus.MemWriteM) begin
               start_wr = 1'b1;
               addr_d   = bus.AddrM & ADDR_MASK;
               wdata_d  = bus.WriteDataM;
               state_d  = WR_WAIT;
            end
         end
         RD_WAIT: begin
            cnt_en = !bus.MemAck;
            if (bus.MemAck) begin
               rdata_d = bus.MemRD;
               state_d = FILL;
            end else if (timeout_tc) begin
               state_d = ERR;
            end
         end
         FILL: begin
            state_d = DONE;
         end
         WR_WAIT: begin
            cnt_en = !bus.MemAck;
            if (bus.MemAck) begin
               state_d = DONE;
            end else if (timeout_tc) begin
               state_d = ERR;
            end
         end
         // DONE always returns to IDLE so the same instruction cannot retrigger.
         DONE: begin
            state_d = IDLE;
         end
         ERR: begin
            state_d = ERR;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      mem_req_d      = (state_d == RD_WAIT) || (state_d == WR_WAIT);
      mem_we_d       = (state_d == WR_WAIT);
      fill_en_d      = (state_d == FILL);
      bypass_valid_d = (state_q == FILL);
      stall_d        = (state_d == RD_WAIT) || (state_d == FILL) ||
                       (state_d == WR_WAIT) || (state_d == ERR);
      err_d          = (state_d == ERR);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q        <= IDLE;
         addr_q         <= '0;
         wdata_q        <= '0;
         rdata_q        <= '0;
         mem_req_q      <= 1'b0;
         mem_we_q       <= 1'b0;
         fill_en_q      <= 1'b0;
         bypass_valid_q <= 1'b0;
         stall_q        <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         rdata_q        <= rdata_d;
         mem_req_q      <= mem_req_d;
         mem_we_q       <= mem_we_d;
         fill_en_q      <= fill_en_d;
         bypass_valid_q <= bypass_valid_d;
         stall_q        <= stall_d;
         err_q          <= err_d;
      end
   end

   assign bus.MemReq      = mem_req_q;
   assign bus.MemWe       = mem_we_q;
   assign bus.MemAddr     = addr_q;
   assign bus.MemWD       = wdata_q;
   assign bus.FillEn      = fill_en_q;
   assign bus.FillAddr    = addr_q;
   assign bus.FillData    = rdata_q;
   assign bus.BypassValid = bypass_valid_q;
   assign bus.BypassData  = rdata_q;
   // The stall must cover the detecting cycle, before any flop has changed.
   assign bus.StallMem    = stall_q | start_rd | start_wr;
   assign bus.ErrTimeout  = err_q;
   assign bus.dbg_state   = state_q;

`ifdef DCACHE_CTRL_STATS_EN
   logic [31:0] miss_cnt_q, miss_cnt_d;
   logic [31:0] write_cnt_q, write_cnt_d;

   always_comb begin
      miss_cnt_d  = miss_cnt_q;
      write_cnt_d = write_cnt_q;
      if (start_rd && (miss_cnt_q != 32'hFFFF_FFFF)) begin
         miss_cnt_d = miss_cnt_q + 32'd1;
      end
      if (start_wr && (write_cnt_q != 32'hFFFF_FFFF)) begin
         write_cnt_d = write_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         miss_cnt_q  <= '0;
         write_cnt_q <= '0;
      end else begin
         miss_cnt_q  <= miss_cnt_d;
         write_cnt_q <= write_cnt_d;
      end
   end

   assign bus.MissCount  = miss_cnt_q;
   assign bus.WriteCount = write_cnt_q;
`else
   assign bus.MissCount  = 32'd0;
   assign bus.WriteCount = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed misses/stores, scoreboarded refill and
// bypass data, final-cycle ack, timeout lock-up and asynchronous reset.
module tb_dcache_ctrl;
   import dcache_ctrl_pkg::*;

   localparam int DW = 32;
   localparam int AW = 17;
   localparam int TO = 8;

   logic clk;
   logic rst_n;

   int n_tests;
   int n_fail;
   int stall_cnt;
   int req_cnt;
   int fill_cnt;
   int byp_cnt;
   int n_miss;
   int n_store;
   logic req_prev;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_fill_q[$];
   logic [AW-1:0] exp_addr_q[$];

   dcache_ctrl_if #(.DATA_WIDTH(DW), .MEM_ADDRESS_WIDTH(AW)) bus ();

   dcache_ctrl #(
      .DATA_WIDTH        (DW),
      .MEM_ADDRESS_WIDTH (AW),
      .TIMEOUT_CYCLES    (TO)
   ) dut (
      .CLK (clk),
      .RST (rst_n),
      .bus (bus.master)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_req"},   32'(bus.MemReq), 0);
      check({tag, "_we"},    32'(bus.MemWe), 0);
      check({tag, "_maddr"}, 32'(bus.MemAddr), 0);
      check({tag, "_mwd"},   bus.MemWD, 0);
      check({tag, "_fill"},  32'(bus.FillEn), 0);
      check({tag, "_faddr"}, 32'(bus.FillAddr), 0);
      check({tag, "_fdata"}, bus.FillData, 0);
      check({tag, "_byp"},   32'(bus.BypassValid), 0);
      check({tag, "_bdata"}, bus.BypassData, 0);
      check({tag, "_stall"}, 32'(bus.StallMem), 0);
      check({tag, "_err"},   32'(bus.ErrTimeout), 0);
      check({tag, "_miss"},  bus.MissCount, 0);
      check({tag, "_wcnt"},  bus.WriteCount, 0);
      check({tag, "_state"}, 32'(bus.dbg_state), 32'(IDLE));
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.StallMem) stall_cnt++;
         if (bus.MemReq && !req_prev) req_cnt++;
         req_prev = bus.MemReq;
         if (bus.FillEn) begin
            fill_cnt++;
            if (exp_fill_q.size() == 0) begin
               check("fill_unexpected", 32'(bus.FillEn), 0);
            end else begin
               check("fill_data", bus.FillData, exp_fill_q.pop_front());
               check("fill_addr", 32'(bus.FillAddr), 32'(exp_addr_q.pop_front()));
            end
         end
         if (bus.BypassValid) begin
            byp_cnt++;
            if (exp_q.size() == 0) begin
               check("bypass_unexpected", 32'(bus.BypassValid), 0);
            end else begin
               check("bypass_data", bus.BypassData, exp_q.pop_front());
            end
         end
      end else begin
         req_prev = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      bus.MemReadM   = 1'b0;
      bus.MemWriteM  = 1'b0;
      bus.HitM       = 1'b0;
      bus.AddrM      = '0;
      bus.WriteDataM = '0;
      bus.MemAck     = 1'b0;
      bus.MemRD      = '0;
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      drive_idle();
      rst_n = 1'b0;
      n_miss  = 0;
      n_store = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle_zero("rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // One load miss or store; MemAck arrives in the delay-th wait cycle.
   task automatic run_access(input logic is_load, input logic both, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data, input int delay);
      logic [AW-1:0] exp_addr;
      int stall0;
      exp_addr = {addr[AW-1:2], 2'b00};
      if (is_load) begin
         exp_q.push_back(data);
         exp_fill_q.push_back(data);
         exp_addr_q.push_back(exp_addr);
         n_miss++;
      end else begin
         n_store++;
      end
      @(posedge clk); #1;
      bus.MemReadM   = is_load;
      bus.MemWriteM  = !is_load || both;
      bus.HitM       = 1'b0;
      bus.AddrM      = addr;
      bus.WriteDataM = is_load ? DW'($urandom) : data;
      bus.MemRD      = is_load ? data : DW'($urandom);
      stall0 = stall_cnt;
      @(negedge clk);
      check("idle_stall", 32'(bus.StallMem), 1);
      for (int i = 1; i <= delay; i++) begin
         @(posedge clk); #1;
         bus.MemAck = (i == delay);
         @(negedge clk);
         check("wait_req", 32'(bus.MemReq), 1);
         check("wait_we", 32'(bus.MemWe), 32'(!is_load));
         check("wait_addr", 32'(bus.MemAddr), 32'(exp_addr));
         if (!is_load) check("wait_wd", bus.MemWD, data);
      end
      @(posedge clk); #1;
      bus.MemAck = 1'b0;
      bus.MemRD  = DW'($urandom);
      if (is_load) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("done_state", 32'(bus.dbg_state), 32'(DONE));
      check("done_stall", 32'(bus.StallMem), 0);
      check("done_byp", 32'(bus.BypassValid), 32'(is_load));
      bus.MemReadM  = 1'b0;
      bus.MemWriteM = 1'b0;
      @(negedge clk);
      check("post_state", 32'(bus.dbg_state), 32'(IDLE));
      check("post_req", 32'(bus.MemReq), 0);
      check("stall_cycles", 32'(stall_cnt - stall0), is_load ? 32'(delay + 2) : 32'(delay + 1));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int req0, fill0, byp0, rd_cycles;
      n_tests = 0;
      n_fail = 0;
      stall_cnt = 0;
      req_cnt = 0;
      fill_cnt = 0;
      byp_cnt = 0;
      req_prev = 1'b0;
      drive_idle();
      rst_n = 1'b0;
      apply_reset();

      // load hit: no stall, no request
      req0 = req_cnt;
      @(posedge clk); #1;
      bus.MemReadM = 1'b1;
      bus.HitM     = 1'b1;
      bus.AddrM    = 17'h00040;
      repeat (3) begin
         @(negedge clk);
         check("hit_stall", 32'(bus.StallMem), 0);
         check("hit_req", 32'(bus.MemReq), 0);
      end
      bus.MemReadM = 1'b0;
      bus.HitM     = 1'b0;
      @(negedge clk);
      check("hit_no_req", 32'(req_cnt - req0), 0);

      // directed load miss and store
      fill0 = fill_cnt;
      byp0  = byp_cnt;
      run_access(1'b1, 1'b0, 17'h00106, 32'hDEADBEEF, 3);
      check("miss_fill_pulses", 32'(fill_cnt - fill0), 1);
      check("miss_byp_pulses", 32'(byp_cnt - byp0), 1);
      req0 = req_cnt;
      run_access(1'b0, 1'b0, 17'h00010, 32'h12345678, 2);
      repeat (2) @(negedge clk);
      check("store_one_req", 32'(req_cnt - req0), 1);

      // read and write both set: read wins
      run_access(1'b1, 1'b1, 17'h1FFFF, 32'hA5A5_0F0F, 1);
      run_access(1'b1, 1'b0, AW'($urandom_range(0, 17'h1FFFF)), $urandom, $urandom_range(1, 5));
      run_access(1'b0, 1'b0, AW'($urandom_range(0, 17'h1FFFF)), $urandom, $urandom_range(1, 5));

`ifdef DCACHE_CTRL_STATS_EN
      check("miss_count", bus.MissCount, 32'(n_miss));
      check("write_count", bus.WriteCount, 32'(n_store));
`else
      check("miss_count_off", bus.MissCount, 0);
      check("write_count_off", bus.WriteCount, 0);
`endif

      // ack in the last counted cycle beats the timeout
      run_access(1'b1, 1'b0, 17'h0ABCD, 32'h0BAD_F00D, TO);
      for (int k = 0; k < 6; k++) begin
         run_access(k[0], 1'b0, AW'($urandom_range(0, 17'h1FFFF)), $urandom, $urandom_range(1, 6));
      end

      // no ack: ERR after TO wait cycles, sticky
      @(posedge clk); #1;
      bus.MemReadM = 1'b1;
      bus.HitM     = 1'b0;
      bus.AddrM    = 17'h00200;
      @(negedge clk);
      rd_cycles = 0;
      for (int i = 0; i < 40 && !bus.ErrTimeout; i++) begin
         @(negedge clk);
         if (bus.dbg_state == RD_WAIT) rd_cycles++;
      end
      check("to_wait_cycles", 32'(rd_cycles), TO);
      bus.MemReadM = 1'b0;
      @(posedge clk); #1;
      bus.MemAck = 1'b1;
      @(posedge clk); #1;
      bus.MemAck = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("err_flag", 32'(bus.ErrTimeout), 1);
         check("err_stall", 32'(bus.StallMem), 1);
         check("err_req", 32'(bus.MemReq), 0);
         check("err_state", 32'(bus.dbg_state), 32'(ERR));
      end
      apply_reset();

      // reset mid RD_WAIT; a late ack afterwards is ignored
      @(posedge clk); #1;
      bus.MemReadM = 1'b1;
      bus.HitM     = 1'b0;
      bus.AddrM    = 17'h00ABC;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("mid_req", 32'(bus.MemReq), 1);
      #2;
      rst_n = 1'b0;
      bus.MemReadM = 1'b0;
      #1;
      check_idle_zero("mid_rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      fill0 = fill_cnt;
      bus.MemAck = 1'b1;
      bus.MemRD  = 32'hCAFE_BABE;
      @(posedge clk); #1;
      bus.MemAck = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("late_ack_state", 32'(bus.dbg_state), 32'(IDLE));
         check("late_ack_req", 32'(bus.MemReq), 0);
         check("late_ack_byp", 32'(bus.BypassValid), 0);
      end
      check("late_ack_no_fill", 32'(fill_cnt - fill0), 0);

      check("exp_q_empty", 32'(exp_q.size()), 0);
      check("exp_fill_q_empty", 32'(exp_fill_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
